stride_sector_coalescer: RTL and testbench
==========================================

// Module: stride_sector_coalescer
// PURPOSE
// Second-generation strided-access transaction generator for the LSU-to-L1 path.
// - Turns one strided warp request (base, signed stride, element size, count) into cache-line transactions.
// - Each transaction carries a per-sector byte-coverage mask.
// - Merges consecutive elements that hit the same line.
// - Splits misaligned elements that straddle a line boundary.
// - Handles negative strides and rejects illegal configurations.
// Sits between the address-generation stage and the L1 miss/request queue.
// PARAMETERS
// ADDR_W        64   address width; all address math is modulo 2^ADDR_W
// COUNT_W       16   element-count width
// LINE_BYTES    128  cache-line size in bytes, power of two
// SECTOR_BYTES  32   sector size in bytes, power of two, divides LINE_BYTES; NSEC = LINE_BYTES/SECTOR_BYTES
// PORTS
// clk             in   1                      clock
// rst             in   1                      asynchronous active-high reset
// req_valid       in   1                      request valid
// req_ready       out  1                      request accepted when req_valid && req_ready
// base_addr       in   ADDR_W                 address of element 0
// stride          in   ADDR_W                 signed two's-complement byte stride
// elem_bytes      in   $clog2(LINE_BYTES)+1   element size in bytes, legal range 1..LINE_BYTES
// elem_count      in   COUNT_W                element count N, legal range >= 1
// mode_span       in   1                      1: emit every line in [min,max] with full mask; 0: coalesced walk
// tx_valid        out  1                      transaction valid
// tx_ready        in   1                      consumer accepts when tx_valid && tx_ready
// tx_addr         out  ADDR_W                 line-aligned address
// tx_sector_mask  out  NSEC                   bit k set = sector k of the line is touched
// tx_last         out  1                      final transaction of this request
// busy            out  1                      request in progress (state != IDLE)
// err_cfg         out  1                      one-cycle pulse: illegal request dropped
// BEHAVIOUR
// Reset (async, rst high):
// - FSM to IDLE; tx_valid, tx_last, busy, err_cfg, tx_sector_mask, tx_addr all 0; pending accumulator cleared.
// - A reset mid-request aborts the request: no tx_last is issued and no partial transaction survives.
// FSM states: IDLE, SPAN, WALK, EMIT, FLUSH.
// IDLE:
// - req_ready=1 only here.
// - On accept, latch all request fields.
// - Illegal request (elem_count==0, elem_bytes==0, elem_bytes>LINE_BYTES): err_cfg=1 next cycle, stay IDLE, emit nothing.
// - Legal request: go to SPAN when mode_span=1, else WALK.
// Address math:
// - addr_i = base + i*stride, product truncated to ADDR_W.
// - Element end = addr_i + elem_bytes - 1.
// - Line = addr & ~(LINE_BYTES-1); sector = (addr % LINE_BYTES) / SECTOR_BYTES.
// SPAN:
// - lo = min(base, addr_{N-1}); hi = max(base, addr_{N-1}) + elem_bytes - 1.
// - Sign of stride selects the min/max operand.
// - Emits line(lo) up to line(hi) in ascending order, LINE_BYTES apart, mask all ones.
// - tx_last is set on line(hi).
// WALK (elements in index order):
// - One element piece is processed per cycle.
// - An element spanning two lines takes two cycles: low-line piece first, then high-line piece.
// - Piece mask covers the sectors from first byte to last byte within that line.
// - Piece line == pending line: OR the piece mask into the pending mask.
// - Otherwise: load pending into tx_* and go to EMIT. On handshake, the new piece becomes pending and WALK resumes.
// - First piece of a request initialises pending without emitting.
// - Dedupe is consecutive-only: a line revisited non-consecutively is emitted again.
// FLUSH:
// - After the last piece of element N-1, emit the pending line with tx_last=1, then return to IDLE.
// Handshake:
// - tx_valid is registered.
// - While tx_valid && !tx_ready, tx_addr, tx_sector_mask and tx_last stay stable and the walk stalls.
// - tx_valid never drops without a handshake except on reset.
// - Back-to-back transactions are allowed: a new tx may load in the same cycle the previous one handshakes.
// busy=0 the cycle after the tx_last handshake.
// Latency: first tx_valid no later than 3 cycles after request accept when tx_ready=1.
// TESTING
// 1. mode0, base=0x1000, stride=4, b=4, N=32 -> one tx: addr 0x1000, mask 0xF, last=1.
// 2. mode0, base=0x107C, b=8, N=1 -> tx 0x1000 mask 0x8 last=0, then tx 0x1080 mask 0x1 last=1.
// 3. mode0, base=0, stride=256, b=4, N=4 -> tx 0x0, 0x100, 0x200, 0x300, each mask 0x1; last only on 0x300.
// 4. mode1, base=0x2000, stride=-128, b=4, N=3 -> tx 0x1F00, 0x1F80, 0x2000, masks 0xF; last on 0x2000.
// 5. Case 3 with tx_ready low 5 cycles on the 2nd tx -> tx fields unchanged through stall; no tx lost or duplicated.
// 6. elem_count=0 -> err_cfg one-cycle pulse, zero tx; next legal request proceeds. rst mid-case-3 -> outputs zero immediately, no tx_last.

Source files
------------

// File: rtl/stride_sector_coalescer.sv
`default_nettype none
// stride_sector_coalescer: turns one strided warp request into cache-line transactions
// carrying per-sector coverage masks, either as a full span or as a consecutive-merge walk.
module stride_sector_coalescer #(
  parameter int ADDR_W       = 64,
  parameter int COUNT_W      = 16,
  parameter int LINE_BYTES   = 128,
  parameter int SECTOR_BYTES = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [ADDR_W-1:0]                    stride,
  input  logic [$clog2(LINE_BYTES):0]          elem_bytes,
  input  logic [COUNT_W-1:0]                   elem_count,
  input  logic                                 mode_span,
  output logic                                 tx_valid,
  input  logic                                 tx_ready,
  output logic [ADDR_W-1:0]                    tx_addr,
  output logic [LINE_BYTES/SECTOR_BYTES-1:0]   tx_sector_mask,
  output logic                                 tx_last,
  output logic                                 busy,
  output logic                                 err_cfg
);

  localparam int NSEC   = LINE_BYTES / SECTOR_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int SEC_SH = $clog2(SECTOR_BYTES);
  localparam int EB_W   = OFF_W + 1;
  localparam int SI_W   = OFF_W - SEC_SH;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAN  = 3'd1,
    S_WALK  = 3'd2,
    S_EMIT  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [EB_W-1:0]     eb_q;
  logic [COUNT_W-1:0]  cnt_q;
  logic [COUNT_W-1:0]  idx;
  logic [ADDR_W-1:0]   cur_addr;
  logic                hi_piece;
  logic                walk_done;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pend_line;
  logic [NSEC-1:0]     pend_mask;
  logic [ADDR_W-1:0]   span_end;

  // Current element piece: the low-line part, or the high-line part of a straddler.
  logic [ADDR_W-1:0]   end_addr;
  logic [ADDR_W-1:0]   line_lo;
  logic [ADDR_W-1:0]   line_hi;
  logic                straddle;
  logic [ADDR_W-1:0]   piece_line;
  logic [SI_W-1:0]     first_sec;
  logic [SI_W-1:0]     last_sec;
  logic [NSEC-1:0]     piece_mask;
  logic [NSEC-1:0]     merged_mask;
  logic                elem_end;
  logic                last_piece;
  logic                same_line;

  assign end_addr    = cur_addr + ADDR_W'(eb_q) - ADDR_W'(1);
  assign line_lo     = cur_addr & LINE_MASK;
  assign line_hi     = end_addr & LINE_MASK;
  assign straddle    = (line_lo != line_hi);
  assign piece_line  = hi_piece ? line_hi : line_lo;
  assign first_sec   = hi_piece ? '0 : cur_addr[OFF_W-1:SEC_SH];
  assign last_sec    = (!hi_piece && straddle) ? '1 : end_addr[OFF_W-1:SEC_SH];
  assign elem_end    = hi_piece || !straddle;
  assign last_piece  = elem_end && (idx == cnt_q - COUNT_W'(1));
  assign same_line   = pend_valid && (piece_line == pend_line);
  assign merged_mask = (pend_valid ? pend_mask : '0) | piece_mask;

  always_comb begin
    piece_mask = '0;
    for (int k = 0; k < NSEC; k++) begin
      if (k >= int'(first_sec) && k <= int'(last_sec)) piece_mask[k] = 1'b1;
    end
  end

  // Span bounds: the stride sign decides which end element is lowest.
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_start;
  logic [ADDR_W-1:0] hi_addr;

  assign last_addr = base_q + ADDR_W'(cnt_q - COUNT_W'(1)) * stride_q;
  assign lo_addr   = stride_q[ADDR_W-1] ? last_addr : base_q;
  assign hi_start  = stride_q[ADDR_W-1] ? base_q : last_addr;
  assign hi_addr   = hi_start + ADDR_W'(eb_q) - ADDR_W'(1);

  logic req_illegal;
  assign req_illegal = (elem_count == '0) || (elem_bytes == '0) ||
                       (elem_bytes > EB_W'(LINE_BYTES));

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      base_q         <= '0;
      stride_q       <= '0;
      eb_q           <= '0;
      cnt_q          <= '0;
      idx            <= '0;
      cur_addr       <= '0;
      hi_piece       <= 1'b0;
      walk_done      <= 1'b0;
      pend_valid     <= 1'b0;
      pend_line      <= '0;
      pend_mask      <= '0;
      span_end       <= '0;
      tx_valid       <= 1'b0;
      tx_addr        <= '0;
      tx_sector_mask <= '0;
      tx_last        <= 1'b0;
      err_cfg        <= 1'b0;
    end else begin
      err_cfg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base_q   <= base_addr;
            stride_q <= stride;
            eb_q     <= elem_bytes;
            cnt_q    <= elem_count;
            if (req_illegal) begin
              err_cfg <= 1'b1;
            end else begin
              cur_addr   <= base_addr;
              idx        <= '0;
              hi_piece   <= 1'b0;
              walk_done  <= 1'b0;
              pend_valid <= 1'b0;
              pend_mask  <= '0;
              state      <= mode_span ? S_SPAN : S_WALK;
            end
          end
        end

        S_SPAN: begin
          if (!tx_valid) begin
            tx_addr        <= lo_addr & LINE_MASK;
            span_end       <= hi_addr & LINE_MASK;
            tx_sector_mask <= '1;
            tx_last        <= ((lo_addr & LINE_MASK) == (hi_addr & LINE_MASK));
            tx_valid       <= 1'b1;
          end else if (tx_ready) begin
            if (tx_last) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_addr <= tx_addr + LINE_STEP;
              tx_last <= ((tx_addr + LINE_STEP) == span_end);
            end
          end
        end

        S_WALK: begin
          if (!pend_valid || same_line) begin
            pend_valid <= 1'b1;
            pend_line  <= piece_line;
            pend_mask  <= merged_mask;
            if (last_piece) begin
              tx_addr        <= piece_line;
              tx_sector_mask <= merged_mask;
              tx_last        <= 1'b1;
              tx_valid       <= 1'b1;
              state          <= S_FLUSH;
            end
          end else begin
            tx_addr        <= pend_line;
            tx_sector_mask <= pend_mask;
            tx_last        <= 1'b0;
            tx_valid       <= 1'b1;
            pend_line      <= piece_line;
            pend_mask      <= piece_mask;
            walk_done      <= last_piece;
            state          <= S_EMIT;
          end
          if (elem_end) begin
            idx      <= idx + COUNT_W'(1);
            cur_addr <= cur_addr + stride_q;
            hi_piece <= 1'b0;
          end else begin
            hi_piece <= 1'b1;
          end
        end

        S_EMIT: begin
          if (tx_ready) begin
            if (walk_done) begin
              tx_addr        <= pend_line;
              tx_sector_mask <= pend_mask;
              tx_last        <= 1'b1;
              state          <= S_FLUSH;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_WALK;
            end
          end
        end

        S_FLUSH: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            pend_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stride_sector_coalescer.sv
`default_nettype none
// Bench for stride_sector_coalescer: stimulus queues hand-computed transactions,
// an independent monitor pops and compares them at every handshake.
module tb_stride_sector_coalescer;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  mask;
    logic        last;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] base_addr = '0;
  logic [63:0] stride = '0;
  logic [7:0]  elem_bytes = '0;
  logic [15:0] elem_count = '0;
  logic        mode_span = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [63:0] tx_addr;
  logic [3:0]  tx_sector_mask;
  logic        tx_last;
  logic        busy;
  logic        err_cfg;

  stride_sector_coalescer #(
    .ADDR_W(64), .COUNT_W(16), .LINE_BYTES(128), .SECTOR_BYTES(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .base_addr(base_addr), .stride(stride), .elem_bytes(elem_bytes),
    .elem_count(elem_count), .mode_span(mode_span),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr),
    .tx_sector_mask(tx_sector_mask), .tx_last(tx_last),
    .busy(busy), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  tx_t sb[$];
  int checks = 0;
  int passed = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_tx(input logic [63:0] a, input logic [3:0] m, input logic l);
    tx_t e;
    e.addr = a; e.mask = m; e.last = l;
    sb.push_back(e);
  endtask

  task automatic send(input logic [63:0] b, input logic [63:0] s, input logic [7:0] eb,
                      input logic [15:0] n, input logic m);
    @(posedge clk); #1;
    req_valid = 1'b1; base_addr = b; stride = s; elem_bytes = eb; elem_count = n; mode_span = m;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Monitor: scoreboard compare at handshakes, stall stability, busy after last.
  logic        have_prev = 1'b0;
  logic        chk_busy  = 1'b0;
  logic [63:0] prev_addr;
  logic [3:0]  prev_mask;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
      chk_busy  = 1'b0;
    end else begin
      if (chk_busy) begin
        check("busy_after_last", 64'(busy), 64'd0);
        chk_busy = 1'b0;
      end
      if (have_prev) begin
        check("stall_valid_held", 64'(tx_valid), 64'd1);
        check("stall_fields_held", {tx_addr[58:0], tx_sector_mask, tx_last},
              {prev_addr[58:0], prev_mask, prev_last});
      end
      if (tx_valid && tx_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_tx: got addr 0x%0h mask 0x%0h last %0b, expected none",
                   tx_addr, tx_sector_mask, tx_last);
        end else begin
          tx_t e;
          e = sb.pop_front();
          check("tx_addr", tx_addr, e.addr);
          check("tx_mask", 64'(tx_sector_mask), 64'(e.mask));
          check("tx_last", 64'(tx_last), 64'(e.last));
          if (tx_last) chk_busy = 1'b1;
        end
      end
      have_prev = tx_valid && !tx_ready;
      prev_addr = tx_addr;
      prev_mask = tx_sector_mask;
      prev_last = tx_last;
    end
  end

  initial begin
    int n;
    int h0;

    // Reset state
    @(negedge clk);
    check("rst_outputs", {58'd0, tx_valid, tx_last, busy, err_cfg, req_ready, 1'b0},
          {58'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("rst_tx_addr", tx_addr, 64'd0);
    check("rst_tx_mask", 64'(tx_sector_mask), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: 32 contiguous words in one line
    expect_tx(64'h1000, 4'hF, 1'b1);
    send(64'h1000, 64'd4, 8'd4, 16'd32, 1'b0);
    wait_idle("case1");

    // 2: single element straddling a line boundary
    expect_tx(64'h1000, 4'h8, 1'b0);
    expect_tx(64'h1080, 4'h1, 1'b1);
    send(64'h107C, 64'd4, 8'd8, 16'd1, 1'b0);
    wait_idle("case2");

    // 3: stride larger than a line, plus first-tx latency
    expect_tx(64'h000, 4'h1, 1'b0);
    expect_tx(64'h100, 4'h1, 1'b0);
    expect_tx(64'h200, 4'h1, 1'b0);
    expect_tx(64'h300, 4'h1, 1'b1);
    send(64'h0, 64'd256, 8'd4, 16'd4, 1'b0);
    n = 0;
    while (!tx_valid && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("first_tx_latency", 64'(tx_valid), 64'd1);
    wait_idle("case3");

    // 4: span mode, negative stride
    expect_tx(64'h1F00, 4'hF, 1'b0);
    expect_tx(64'h1F80, 4'hF, 1'b0);
    expect_tx(64'h2000, 4'hF, 1'b1);
    send(64'h2000, 64'hFFFF_FFFF_FFFF_FF80, 8'd4, 16'd3, 1'b1);
    wait_idle("case4");

    // 5: case 3 with a 5-cycle stall on the second transaction
    expect_tx(64'h000, 4'h1, 1'b0);
    expect_tx(64'h100, 4'h1, 1'b0);
    expect_tx(64'h200, 4'h1, 1'b0);
    expect_tx(64'h300, 4'h1, 1'b1);
    h0 = hs_count;
    send(64'h0, 64'd256, 8'd4, 16'd4, 1'b0);
    n = 0;
    while (hs_count < h0 + 1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1 tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check("stall_tx_addr", tx_addr, 64'h100);
    check("stall_hs_count", 64'(hs_count - h0), 64'd1);
    tx_ready = 1'b1;
    wait_idle("case5");

    // 6a: illegal request -> one-cycle err pulse, no transactions
    send(64'h1000, 64'd4, 8'd4, 16'd0, 1'b0);
    @(negedge clk);
    check("err_pulse_high", {62'd0, err_cfg, busy}, {62'd0, 1'b1, 1'b0});
    @(negedge clk);
    check("err_pulse_low", 64'(err_cfg), 64'd0);
    expect_tx(64'h1000, 4'hF, 1'b1);
    send(64'h1000, 64'd4, 8'd4, 16'd32, 1'b0);
    wait_idle("after_err");

    // 6b: reset in the middle of case 3
    expect_tx(64'h000, 4'h1, 1'b0);
    expect_tx(64'h100, 4'h1, 1'b0);
    expect_tx(64'h200, 4'h1, 1'b0);
    expect_tx(64'h300, 4'h1, 1'b1);
    h0 = hs_count;
    send(64'h0, 64'd256, 8'd4, 16'd4, 1'b0);
    n = 0;
    while (hs_count < h0 + 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    rst = 1'b1;
    #1;
    check("midrst_outputs", {60'd0, tx_valid, tx_last, busy, err_cfg}, 64'd0);
    check("midrst_tx_addr", tx_addr, 64'd0);
    check("midrst_tx_mask", 64'(tx_sector_mask), 64'd0);
    sb.delete();
    h0 = hs_count;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_more_tx", 64'(hs_count), 64'(h0));

    // Recovery after reset
    expect_tx(64'h1000, 4'h8, 1'b0);
    expect_tx(64'h1080, 4'h1, 1'b1);
    send(64'h107C, 64'd4, 8'd8, 16'd1, 1'b0);
    wait_idle("after_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
